// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded ID instruction in, pipeline control and forward selects out.
interface hazard_scoreboard_if #(
  parameter int AW = 5
);
  logic [2:0]    optype_ID;
  logic [AW-1:0] rs1_ID;
  logic [AW-1:0] rs2_ID;
  logic          rs1use_ID;
  logic          rs2use_ID;
  logic [AW-1:0] rd_ID;
  logic          Branch_ID;
  logic          PC_EN_IF;
  logic          reg_FD_stall;
  logic          reg_FD_flush;
  logic          reg_DE_flush;
  logic [1:0]    forward_ctrl_A;
  logic [1:0]    forward_ctrl_B;
  logic          forward_ctrl_ls;
  logic          mul_busy;
  logic          mul_wb;

  modport master (
    output optype_ID, rs1_ID, rs2_ID, rs1use_ID, rs2use_ID, rd_ID, Branch_ID,
    input  PC_EN_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mul_busy, mul_wb
  );

  modport slave (
    input  optype_ID, rs1_ID, rs2_ID, rs1use_ID, rs2use_ID, rd_ID, Branch_ID,
    output PC_EN_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mul_busy, mul_wb
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: tracks EX/MEM occupants and the multi-cycle multiplier, and produces
// stall, flush and forward selects combinationally from the ID instruction and that state.
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int MUL_LAT = 4,
  parameter int FWD_EN  = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  hazard_scoreboard_if.slave hz_if
);
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_ALU   = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

  // WB occupant is not kept: the regfile writes before it is read, so it never stalls or forwards.
  logic [2:0]    ex_op_q, ex_op_d, mem_op_q, mem_op_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d, ex_rs2_q, ex_rs2_d, mem_rd_q, mem_rd_d;
  logic [AW-1:0] mul_rd_q, mul_rd_d;
  logic [3:0]    cnt_q, cnt_d;

  logic [2:0] id_op;
  logic       ex_rm1, ex_rm2, mem_rm1, mem_rm2, mul_rm1, mul_rm2;
  logic       busy, id_writes, stall;
  logic       s_load, s_nofwd, s_mul, s_struct;

  function automatic logic rd_match(input logic use_b, input logic [AW-1:0] rs,
                                    input logic [AW-1:0] rd);
    return use_b && (rs == rd) && (rd != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m,
                                         input logic [2:0] ex_op, input logic [2:0] mem_op);
    if (ex_op == OP_ALU && ex_m)         return 2'b01;
    else if (mem_op == OP_ALU && mem_m)  return 2'b10;
    else if (mem_op == OP_LOAD && mem_m) return 2'b11;
    else                                 return 2'b00;
  endfunction

  always_comb begin
    id_op     = (hz_if.optype_ID > OP_MUL) ? OP_NONE : hz_if.optype_ID;
    id_writes = (id_op == OP_ALU || id_op == OP_LOAD || id_op == OP_MUL) && (hz_if.rd_ID != '0);
    busy      = (cnt_q != 4'd0);

    ex_rm1  = rd_match(hz_if.rs1use_ID, hz_if.rs1_ID, ex_rd_q);
    ex_rm2  = rd_match(hz_if.rs2use_ID, hz_if.rs2_ID, ex_rd_q);
    mem_rm1 = rd_match(hz_if.rs1use_ID, hz_if.rs1_ID, mem_rd_q);
    mem_rm2 = rd_match(hz_if.rs2use_ID, hz_if.rs2_ID, mem_rd_q);
    mul_rm1 = rd_match(hz_if.rs1use_ID, hz_if.rs1_ID, mul_rd_q);
    mul_rm2 = rd_match(hz_if.rs2use_ID, hz_if.rs2_ID, mul_rd_q);

    // store data can still be picked up from MEM load data, so rs2 of a store is exempt
    s_load   = (ex_op_q == OP_LOAD) && (ex_rm1 || (ex_rm2 && id_op != OP_STORE));
    s_nofwd  = (FWD_EN == 0) &&
               (((ex_op_q == OP_ALU || ex_op_q == OP_LOAD) && (ex_rm1 || ex_rm2)) ||
                ((mem_op_q == OP_ALU || mem_op_q == OP_LOAD) && (mem_rm1 || mem_rm2)));
    s_mul    = busy && (mul_rm1 || mul_rm2 || (id_writes && hz_if.rd_ID == mul_rd_q));
    s_struct = busy && (id_op == OP_MUL);
    stall    = s_load || s_nofwd || s_mul || s_struct;

    hz_if.PC_EN_IF     = !stall;
    hz_if.reg_FD_stall = stall;
    hz_if.reg_FD_flush = hz_if.Branch_ID && !stall;
    hz_if.reg_DE_flush = stall;
    hz_if.mul_busy     = busy;
    hz_if.mul_wb       = (cnt_q == 4'd1);

    hz_if.forward_ctrl_A = 2'b00;
    hz_if.forward_ctrl_B = 2'b00;
    if (FWD_EN != 0 && !stall) begin
      hz_if.forward_ctrl_A = fwd_sel(ex_rm1, mem_rm1, ex_op_q, mem_op_q);
      hz_if.forward_ctrl_B = fwd_sel(ex_rm2, mem_rm2, ex_op_q, mem_op_q);
    end
    hz_if.forward_ctrl_ls = (ex_op_q == OP_STORE) && (mem_op_q == OP_LOAD) &&
                            (ex_rs2_q == mem_rd_q) && (mem_rd_q != '0);
  end

  always_comb begin
    ex_op_d  = stall ? OP_NONE : id_op;
    ex_rd_d  = stall ? '0 : hz_if.rd_ID;
    ex_rs2_d = stall ? '0 : hz_if.rs2_ID;
    mem_op_d = ex_op_q;
    mem_rd_d = ex_rd_q;
    mul_rd_d = mul_rd_q;
    cnt_d    = cnt_q;
    if (id_op == OP_MUL && !stall) begin
      cnt_d    = MUL_LAT_C;
      mul_rd_d = hz_if.rd_ID;
    end else if (busy) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_op_q  <= OP_NONE;
      ex_rd_q  <= '0;
      ex_rs2_q <= '0;
      mem_op_q <= OP_NONE;
      mem_rd_q <= '0;
      mul_rd_q <= '0;
      cnt_q    <= 4'd0;
    end else begin
      ex_op_q  <= ex_op_d;
      ex_rd_q  <= ex_rd_d;
      ex_rs2_q <= ex_rs2_d;
      mem_op_q <= mem_op_d;
      mem_rd_q <= mem_rd_d;
      mul_rd_q <= mul_rd_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
